down_count: RTL and testbench
=============================

# down_count

Loadable, enable-gated down counter: the decrementing counterpart of the team's `up_count`. It accepts a start value, counts down to zero under `en`, and flags terminal count with a single-cycle pulse. It is the countdown and timeout source for the DAY-series control blocks, and it is sized by parameter.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  synchronous load strobe. Has priority over `en`.
- `load_val`  in  WIDTH  start value, captured when `load`=1.
- `en`  in  1  count enable.
- `out`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered, one cycle wide.
- `zero`  out  1  high when `out`==0, registered.
- `busy`  out  1  high while state is RUN.

## Operation
- States:
  - IDLE: after reset, or after a load of 0.
  - RUN: counting.
  - DONE: reached zero; non-reload build only.
- Reset, applied asynchronously:
  - `out`=0, `tc`=0, `zero`=1, `busy`=0.
  - State = IDLE.
  - Reload register = 0.
- `load`=1, in any state:
  - `out`←`load_val` and reload register←`load_val`.
  - `tc`=0 on the following cycle.
  - Next state is RUN if `load_val`≠0, otherwise IDLE.
- RUN with `en`=1 and `load`=0:
  - `out`←`out`−1.
  - When `out`==1, the result is 0 and `tc`=1 for exactly that one cycle (same edge at which `out` becomes 0).
- RUN with `en`=0: `out` holds, `busy` stays 1. No separate pause state.
- IDLE and DONE:
  - `en` is ignored.
  - `out` holds its value; it never wraps to 2^WIDTH−1.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow is unreachable by construction.
- Simultaneous `load` and terminal step: load wins, and no `tc` pulse is produced.
- `rst` mid-count: immediate clear to reset values. No pulse is emitted.

## Timing
- Load latency: 1 cycle. `out` shows `load_val` after the edge that sampled `load`.
- Load N≥1 at edge 0, then `en`=1 continuously:
  - `out` = N−k after edge k.
  - After edge N: `out`=0, `tc`=1, `zero`=1, `busy`=0 (non-reload).
- `tc` drops on the next edge unless another terminal step occurs.
- Reload build, period = N+1 enabled cycles:
  - After edge N: `out`=0 with `tc`=1.
  - Edge N+1: `out`=N.
  - The cycle repeats while `en`=1.
- `zero` and `busy` are updated on the same edge as `out`. They never lead or lag it.

## Configuration
- Macro: `DOWN_COUNT_RELOAD_EN`.
- Defined (auto-reload):
  - The DONE state does not exist. State stays RUN at zero.
  - The next enabled cycle reloads `out` from the reload register.
  - `busy` stays 1 until `rst` or a load of 0.
- Undefined (one-shot):
  - At zero the state moves RUN→DONE.
  - `out` holds 0 and `busy`=0 until the next `load`.

## Structure
- Package `down_count_pkg` holds the state enum (IDLE, RUN, DONE) and the default width constant `DOWN_COUNT_WIDTH`=4.
- Single module, no sub-module. The `tc` and `zero` register logic lives inline.

## Test plan
- Reset: `rst`=1 mid-count at `out`=7 → next sample shows `out`=0, `zero`=1, `busy`=0, `tc`=0 with no clock edge required.
- One-shot: load 5, `en`=1 → `out` 5,4,3,2,1,0; `tc`=1 only in the cycle `out`=0; `out` stays 0 for 10 further cycles (no wrap to 15).
- Enable gating: load 9, `en` toggled 1,0,0,1 → `out` 8,8,8,7; `busy`=1 throughout.
- Load priority: at `out`=1, assert `load`=1 (`load_val`=12) with `en`=1 → `out`=12, `tc` stays 0.
- Zero load: load 0 with `en`=1 → state IDLE, `out`=0, `busy`=0, no `tc` pulse.
- Reload (`DOWN_COUNT_RELOAD_EN`): load 3, `en`=1 for 12 cycles → `out` 3,2,1,0,3,2,1,0,…; `tc` pulses every 4th cycle, three pulses total.

Source files
------------

// File: rtl/down_count_pkg.sv
// Shared types and constants for the loadable down counter.
package down_count_pkg;

    localparam int DOWN_COUNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dc_state_e;

endpackage

// File: rtl/down_count.sv
// Loadable, enable-gated down counter with registered terminal-count pulse.
// Define DOWN_COUNT_RELOAD_EN for auto-reload; default build is one-shot.
module down_count
    import down_count_pkg::*;
#(
    parameter int WIDTH = DOWN_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             zero,
    output logic             busy
);

    dc_state_e        state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            out_d    = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (en) begin
                        if (out_q == '0) begin
                            // Only reachable in the auto-reload build
                            out_d = reload_q;
                        end else begin
                            out_d = out_q - WIDTH'(1);
                            if (out_q == WIDTH'(1)) begin
                                tc_d = 1'b1;
`ifndef DOWN_COUNT_RELOAD_EN
                                state_d = DONE;
`endif
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        zero_d = (out_d == '0);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign zero = zero_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_down_count.sv
// Directed self-checking bench for down_count (one-shot or reload build).
module tb_down_count;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic [3:0] out;
    logic       tc;
    logic       zero;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    down_count #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .out      (out),
        .tc       (tc),
        .zero     (zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; load_val = 4'd0; en = 1'b0;
        #2;
        n_checks++;
        if (out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: out=%0d zero=%b busy=%b tc=%b want 0 1 0 0",
                     out, zero, busy, tc);
        end
        step();
        rst = 1'b0;
        load = 1'b1; load_val = 4'd9; en = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        n_checks++;
        if (out !== 4'd7) begin
            n_fail++;
            $display("FAIL reset_precount: out=%0d want 7", out);
        end
        rst = 1'b1;
        #2;
        n_checks++;
        if (out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out=%0d zero=%b busy=%b tc=%b want 0 1 0 0",
                     out, zero, busy, tc);
        end
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        load = 1'b1; load_val = 4'd5; en = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 4'd5 || tc !== 1'b0 || busy !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_load: out=%0d tc=%b busy=%b zero=%b want 5 0 1 0",
                     out, tc, busy, zero);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if (out !== 4'(5 - k) || tc !== (k == 5) || zero !== (k == 5)
                || busy !== (k != 5)) begin
                n_fail++;
                $display("FAIL oneshot_count k=%0d: out=%0d tc=%b zero=%b busy=%b want %0d %b %b %b",
                         k, out, tc, zero, busy, 5 - k, k == 5, k == 5, k != 5);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_hold k=%0d: out=%0d tc=%b busy=%b zero=%b want 0 0 0 1",
                         k, out, tc, busy, zero);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_enable();
        logic [3:0] en_seq [4];
        logic [3:0] exp_seq [4];
        en_seq  = '{4'd1, 4'd0, 4'd0, 4'd1};
        exp_seq = '{4'd8, 4'd8, 4'd8, 4'd7};
        load = 1'b1; load_val = 4'd9; en = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i][0];
            step();
            n_checks++;
            if (out !== exp_seq[i] || busy !== 1'b1 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_gate i=%0d: out=%0d busy=%b tc=%b want %0d 1 0",
                         i, out, busy, tc, exp_seq[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 4'd2; en = 1'b1;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (out !== 4'd1) begin
            n_fail++;
            $display("FAIL prio_setup: out=%0d want 1", out);
        end
        load = 1'b1; load_val = 4'd12;
        step();
        load = 1'b0; en = 1'b0;
        n_checks++;
        if (out !== 4'd12 || tc !== 1'b0 || busy !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_load: out=%0d tc=%b busy=%b zero=%b want 12 0 1 0",
                     out, tc, busy, zero);
        end
        step();
        n_checks++;
        if (out !== 4'd12 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_after: out=%0d tc=%b want 12 0", out, tc);
        end
    endtask

    task automatic test_zero_load();
        load = 1'b1; load_val = 4'd0; en = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_load k=%0d: out=%0d busy=%b tc=%b zero=%b want 0 0 0 1",
                         k, out, busy, tc, zero);
            end
            step();
        end
        en = 1'b0;
    endtask

`ifdef DOWN_COUNT_RELOAD_EN
    task automatic test_reload();
        int pulses;
        pulses = 0;
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (out !== 4'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_load: out=%0d busy=%b want 3 1", out, busy);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tc === 1'b1) pulses++;
            n_checks++;
            if (out !== 4'(3 - (k % 4)) || tc !== ((k % 4) == 3) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reload_cycle k=%0d: out=%0d tc=%b busy=%b want %0d %b 1",
                         k, out, tc, busy, 3 - (k % 4), (k % 4) == 3);
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL reload_pulses: got %0d want 3", pulses);
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifndef DOWN_COUNT_RELOAD_EN
        test_oneshot();
`endif
        test_enable();
        test_load_priority();
        test_zero_load();
`ifdef DOWN_COUNT_RELOAD_EN
        test_reload();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
